// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: accept, LATENCY wait cycles, then commit store / return load with a DVALID pulse.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [31:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic        DVALID,
    output logic        STALL,
    output logic        DERR
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_rw;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_direct;
    logic                  w_acc_rw;
    logic                  w_acc_mis;
    logic                  w_mis_in;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [31:0]           w_acc_wdata;
    logic                  w_unused;

    assign w_accept = (r_state == S_IDLE) && DREQ;
    assign w_access = (w_accept && (LATENCY == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

    // With zero latency the access happens on the accept edge, so fields come straight from the ports.
    assign w_direct    = (r_state == S_IDLE);
    assign w_acc_rw    = w_direct ? DRW : r_rw;
    assign w_acc_idx   = w_direct ? DADDR[DEPTH_LOG2+1:2] : r_idx;
    assign w_acc_wdata = w_direct ? DWDATA : r_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_mis;
    logic r_derr;

    assign w_mis_in  = (DADDR[1:0] != 2'b00);
    assign w_acc_mis = w_direct ? w_mis_in : r_mis;
    assign DERR      = r_derr;
    assign w_unused  = ^DADDR[31:DEPTH_LOG2+2];

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_mis  <= 1'b0;
            r_derr <= 1'b0;
        end else if (w_accept) begin
            r_mis <= w_mis_in;
            if (w_mis_in) begin
                r_derr <= 1'b1;
            end
        end
    end
`else
    assign w_mis_in  = 1'b0;
    assign w_acc_mis = w_mis_in;
    assign DERR      = 1'b0;
    assign w_unused  = ^{DADDR[31:DEPTH_LOG2+2], DADDR[1:0]};
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (DREQ) begin
                    w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        DVALID = (r_state == S_RESP);
        STALL  = ((r_state == S_IDLE) && DREQ) || (r_state == S_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_rw    <= DRW;
                r_idx   <= DADDR[DEPTH_LOG2+1:2];
                r_wdata <= DWDATA;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !w_acc_rw) begin
                r_rdata <= w_acc_mis ? '0 : r_mem[w_acc_idx];
            end
        end
    end

    // Array is not reset; gating with RSTN keeps a store abandoned by reset from committing.
    always_ff @(posedge CLK) begin
        if (RSTN && w_access && w_acc_rw && !w_acc_mis) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    assign DRDATA = r_rdata;

endmodule
